// File: rtl/rca_seq_pkg.sv
// Shared constants, state encoding and helpers for the sliced ripple-carry sequencer.
package rca_seq_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slice-index register width; a single slice still needs one bit.
    function automatic int unsigned idx_width(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Purely combinational 4-bit ripple-carry adder built from full-adder cells.
module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/rca_word_sequencer.sv
// WIDTH-bit add/subtract built on one shared 4-bit adder, one slice per clock, LSB slice first.
// Valid/ready on both the operand and the result side; operations never overlap.
module rca_word_sequencer
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int          NSLICE = WIDTH / int'(SLICE_W);
    localparam int unsigned IW     = idx_width(NSLICE);

    if (((WIDTH % int'(SLICE_W)) != 0) || (WIDTH < int'(SLICE_W))) begin : g_bad_width
        $error("rca_word_sequencer: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t               state;
    logic [IW-1:0]        idx;
    logic                 carry;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [SLICE_W-1:0]   a_sl;
    logic [SLICE_W-1:0]   b_sl;
    logic [SLICE_W-1:0]   s_sl;
    logic                 c_out;
    logic                 last;

    // b_reg already holds ~B for subtract, so the adder only ever adds.
    assign a_sl = a_reg[idx * SLICE_W +: SLICE_W];
    assign b_sl = b_reg[idx * SLICE_W +: SLICE_W];
    assign last = (idx == IW'(NSLICE - 1));

    assign in_ready = rst_n && (state == ST_IDLE);

    ripple_carry_adder u_rca (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (s_sl),
        .cout (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_sub ? ~in_b : in_b;
                        carry <= in_sub ? 1'b1 : in_cin;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    out_sum[idx * SLICE_W +: SLICE_W] <= s_sl;
                    carry                             <= c_out;
                    if (last) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out_cout  <= c_out;
                        out_ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                                     && (s_sl[SLICE_W-1] != a_reg[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Directed and randomized checks of rca_word_sequencer (WIDTH=16) against an integer-arithmetic model.
module tb_rca_word_sequencer;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;
    localparam int BOUND  = 40;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int total = 0;
    int bad   = 0;

    rca_word_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, output logic [15:0] s, output logic co,
                         output logic ov);
        int ua, ub, sa, sb, r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            s  = a - b;
            co = (ua >= ub);
            r  = sa - sb;
        end else begin
            s  = a + b + {15'd0, cin};
            co = ((ua + ub + int'(cin)) > 65535);
            r  = sa + sb + int'(cin);
        end
        ov = (r > 32767) || (r < -32768);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < BOUND) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Returns edges counted after the call until out_valid is seen.
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!out_valid && n < BOUND) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) check({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b,
                                input logic cin, input logic sub);
        logic [15:0] s;
        logic        co, ov;
        model(a, b, cin, sub, s, co, ov);
        check({tag, "_sum"}, 32'(out_sum), 32'(s));
        check({tag, "_cout"}, 32'(out_cout), 32'(co));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(ov));
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input int stall);
        int          n;
        logic [15:0] held;
        wait_ready(tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        @(posedge clk);
        #1;
        // Operand changes after the accept edge must have no effect.
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_cin   = 1'($urandom);
        in_sub   = 1'($urandom);
        wait_valid(tag, n);
        check({tag, "_latency"}, 32'(n), 32'(NSLICE));
        check_result(tag, a, b, cin, sub);
        held = out_sum;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_stall_sum"}, 32'(out_sum), 32'(held));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_post_sum_held"}, 32'(out_sum), 32'(held));
    endtask

    initial begin
        logic [15:0] held_sum;
        logic        held_cout, held_ovf;
        int          n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors.
        run_op("add_basic", 16'h1234, 16'h0FF0, 1'b0, 1'b0, 0);
        check("add_basic_const", 32'(out_sum), 32'h2224);
        run_op("ripple_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        check("ripple_carry_const", 32'(out_sum), 32'h0000);
        run_op("ripple_cin", 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1);
        check("ripple_cin_const", 32'(out_sum), 32'hFFFF);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        check("sub_borrow_const", 32'(out_sum), 32'hFFFE);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 2);
        check("sub_ovf_const", 32'({out_sum, out_cout, out_ovf}), 32'({16'h7FFF, 1'b1, 1'b1}));
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        check("add_ovf_const", 32'({out_sum, out_cout, out_ovf}), 32'({16'h8000, 1'b0, 1'b1}));

        // Backpressure with a second request held during RUN and DONE.
        wait_ready("bp");
        in_valid = 1'b1;
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        in_cin   = 1'b1;
        in_sub   = 1'b0;
        @(posedge clk);
        #1;
        in_a   = 16'h0F0F;
        in_b   = 16'h0101;
        in_cin = 1'b0;
        in_sub = 1'b1;
        check("bp_busy_ready", 32'(in_ready), 32'd0);
        wait_valid("bp", n);
        check("bp_latency", 32'(n), 32'(NSLICE));
        check_result("bp_first", 16'h1111, 16'h2222, 1'b1, 1'b0);
        held_sum  = out_sum;
        held_cout = out_cout;
        held_ovf  = out_ovf;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
            check("bp_hold_out", 32'({out_sum, out_cout, out_ovf}),
                  32'({held_sum, held_cout, held_ovf}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_accepted", 32'(in_ready), 32'd0);
        wait_valid("bp2", n);
        check("bp2_latency", 32'(n), 32'(NSLICE));
        check_result("bp_second", 16'h0F0F, 16'h0101, 1'b0, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset two cycles into RUN discards the operation.
        wait_ready("mid_rst");
        in_valid = 1'b1;
        in_a     = 16'hABCD;
        in_b     = 16'h1357;
        in_sub   = 1'b0;
        in_cin   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", 32'({out_valid, out_sum, out_cout, out_ovf}), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("mid_rst_hold_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_release_ready", 32'(in_ready), 32'd1);
        check("mid_rst_release_valid", 32'(out_valid), 32'd0);
        run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 0);
        check("after_rst_const", 32'(out_sum), 32'h0002);

        // Randomized operations with random consumer stalls.
        for (int k = 0; k < 30; k++) begin
            run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
